// File: rtl/gb_rtc_backup.sv
// gb_rtc_backup: moves MBC3 RTC state between the save-file stream and the mapper.
//   Load: collects the 5-word RTC footer (img_*), validates it, replays it to the
//         mapper as a burst of bk_rtc_wr strobes, then pulses load_done.
//   Save: snap_req freezes a coherent snapshot, read word by word via rd_addr/rd_data.
//   rtc_dirty flags divergence of the live RTC registers from the last snapshot.
// Ports: clk_sys/reset_n (async active-low), enable, load_start, img_wr/img_addr/img_data,
//        bk_rtc_wr/bk_addr/bk_data, load_done, load_err, RTC_timestampOut, RTC_savedtimeOut,
//        RTC_inuse, snap_req, rd_addr, rd_data, busy, rtc_dirty.
module gb_rtc_backup (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        load_start,
    input  logic        img_wr,
    input  logic [2:0]  img_addr,
    input  logic [15:0] img_data,
    output logic        bk_rtc_wr,
    output logic [7:0]  bk_addr,
    output logic [15:0] bk_data,
    output logic        load_done,
    output logic        load_err,
    input  logic [31:0] RTC_timestampOut,
    input  logic [47:0] RTC_savedtimeOut,
    input  logic        RTC_inuse,
    input  logic        snap_req,
    input  logic [2:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        rtc_dirty
);
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned ADDR_W  = 8;
    localparam logic [WORD_W-1:0] MAGIC = 16'h5254;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;
    localparam logic [1:0] ST_SNAP    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        mask_q, mask_d;
    logic [WORD_W-1:0] shadow_q [4];
    logic [WORD_W-1:0] shadow_d [4];
    logic              pend_q, pend_d;
    logic [31:0]       snap_ts_q, snap_ts_d;
    logic [31:0]       snap_sv_q, snap_sv_d;
    logic              snap_use_q, snap_use_d;
    logic              dirty_q, dirty_d;
    logic              err_q, err_d;
    logic              bk_wr_q, bk_wr_d;
    logic [ADDR_W-1:0] bk_addr_q, bk_addr_d;
    logic [WORD_W-1:0] bk_data_q, bk_data_d;
    logic              done_q, done_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              busy_q, busy_d;
    logic              capture;
    logic [3:0]        mask_v;

    // Upper savedtime bits carry no state this block needs.
    logic unused_sv_hi;
    assign unused_sv_hi = ^RTC_savedtimeOut[47:32];

    // State register and all output/storage flops.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
            pend_q     <= 1'b0;
            snap_ts_q  <= '0;
            snap_sv_q  <= '0;
            snap_use_q <= 1'b0;
            dirty_q    <= 1'b0;
            err_q      <= 1'b0;
            bk_wr_q    <= 1'b0;
            bk_addr_q  <= '0;
            bk_data_q  <= '0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            for (int i = 0; i < 4; i++) shadow_q[i] <= shadow_d[i];
            pend_q     <= pend_d;
            snap_ts_q  <= snap_ts_d;
            snap_sv_q  <= snap_sv_d;
            snap_use_q <= snap_use_d;
            dirty_q    <= dirty_d;
            err_q      <= err_d;
            bk_wr_q    <= bk_wr_d;
            bk_addr_q  <= bk_addr_d;
            bk_data_q  <= bk_data_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, storage updates and registered-output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        snap_ts_d  = snap_ts_q;
        snap_sv_d  = snap_sv_q;
        snap_use_d = snap_use_q;
        dirty_d    = dirty_q;
        err_d      = err_q;
        bk_wr_d    = 1'b0;
        bk_addr_d  = '0;
        bk_data_d  = '0;
        done_d     = 1'b0;
        capture    = 1'b0;
        mask_v     = mask_q;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            mask_d  = '0;
            pend_d  = 1'b0;
            dirty_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    // load_start clears first so a same-cycle write lands in the new load.
                    if (load_start) begin
                        mask_v  = '0;
                        err_d   = 1'b0;
                        state_d = ST_COLLECT;
                    end
                    if (img_wr && (state_q == ST_COLLECT || load_start)) begin
                        if (img_addr < 3'd4) begin
                            shadow_d[img_addr[1:0]] = img_data;
                            mask_v[img_addr[1:0]]   = 1'b1;
                        end else if (img_addr == 3'd4) begin
                            if (img_data == MAGIC && mask_v == 4'hF) begin
                                state_d = ST_EMIT;
                                cnt_d   = '0;
                            end else begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    mask_d  = mask_v;
                    capture = snap_req;
                end
                ST_EMIT: begin
                    if (snap_req) pend_d = 1'b1;
                    // Counter 0..4 emits words; counter 5 is the load_done cycle.
                    if (cnt_q <= 3'd4) begin
                        bk_wr_d   = 1'b1;
                        bk_addr_d = ADDR_W'(cnt_q);
                        bk_data_d = (cnt_q == 3'd4) ? '0 : shadow_q[cnt_q[1:0]];
                        cnt_d     = cnt_q + 3'd1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = (pend_q || snap_req) ? ST_SNAP : ST_IDLE;
                    end
                end
                ST_SNAP: begin
                    capture = 1'b1;
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (RTC_inuse && (RTC_savedtimeOut[28:0] != snap_sv_q[28:0])) dirty_d = 1'b1;
            // Capture takes priority over a same-cycle dirty set.
            if (capture) begin
                snap_ts_d  = RTC_timestampOut;
                snap_sv_d  = RTC_savedtimeOut[31:0];
                snap_use_d = RTC_inuse;
                dirty_d    = 1'b0;
            end
        end

        busy_d = (state_d == ST_EMIT) || (state_d == ST_SNAP) || pend_d;
    end

    // Snapshot read port; uses the pre-capture snapshot on a same-cycle snap_req.
    always_comb begin
        case (rd_addr)
            3'd0:    rd_data_d = snap_ts_q[15:0];
            3'd1:    rd_data_d = snap_ts_q[31:16];
            3'd2:    rd_data_d = snap_sv_q[15:0];
            3'd3:    rd_data_d = snap_sv_q[31:16];
            3'd4:    rd_data_d = snap_use_q ? MAGIC : '0;
            default: rd_data_d = 16'hFFFF;
        endcase
    end

    assign bk_rtc_wr = bk_wr_q;
    assign bk_addr   = bk_addr_q;
    assign bk_data   = bk_data_q;
    assign load_done = done_q;
    assign load_err  = err_q;
    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign rtc_dirty = dirty_q;
endmodule

// File: tb/tb_gb_rtc_backup.sv
// Directed/randomized bench for gb_rtc_backup with a word-level reference model.
module tb_gb_rtc_backup;
    localparam logic [15:0] MAGIC = 16'h5254;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        load_start = 1'b0;
    logic        img_wr = 1'b0;
    logic [2:0]  img_addr = '0;
    logic [15:0] img_data = '0;
    logic        bk_rtc_wr;
    logic [7:0]  bk_addr;
    logic [15:0] bk_data;
    logic        load_done;
    logic        load_err;
    logic [31:0] RTC_timestampOut = '0;
    logic [47:0] RTC_savedtimeOut = '0;
    logic        RTC_inuse = 1'b0;
    logic        snap_req = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        busy;
    logic        rtc_dirty;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    logic [15:0] ref_shadow [4];

    gb_rtc_backup dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable),
        .load_start(load_start), .img_wr(img_wr), .img_addr(img_addr), .img_data(img_data),
        .bk_rtc_wr(bk_rtc_wr), .bk_addr(bk_addr), .bk_data(bk_data),
        .load_done(load_done), .load_err(load_err),
        .RTC_timestampOut(RTC_timestampOut), .RTC_savedtimeOut(RTC_savedtimeOut),
        .RTC_inuse(RTC_inuse), .snap_req(snap_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .rtc_dirty(rtc_dirty)
    );

    always #5 clk_sys = ~clk_sys;

    // Count strobes and done pulses mid-cycle.
    always @(negedge clk_sys) begin
        if (bk_rtc_wr) strobe_cnt <= strobe_cnt + 1;
        if (load_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        img_wr = 1'b1; img_addr = a; img_data = d;
        tick();
        img_wr = 1'b0;
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Save-footer word the host should read for a given snapshot.
    function automatic logic [15:0] footer_word(input logic [31:0] ts, input logic [31:0] sv,
                                                input logic use_f, input int a);
        logic [15:0] w [5];
        w[0] = ts[15:0];  w[1] = ts[31:16];
        w[2] = sv[15:0];  w[3] = sv[31:16];
        w[4] = use_f ? MAGIC : 16'h0000;
        return (a < 5) ? w[a] : 16'hFFFF;
    endfunction

    task automatic check_snapshot(input string tag, input logic [31:0] ts,
                                  input logic [31:0] sv, input logic use_f);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            tick();
            check(tag, 64'(rd_data), 64'(footer_word(ts, sv, use_f, a)));
        end
    endtask

    task automatic load_all_words();
        for (int i = 0; i < 4; i++) begin
            ref_shadow[i] = 16'($urandom);
            write_word(3'(i), ref_shadow[i]);
        end
    endtask

    initial begin
        int s0, d0, n;
        logic [31:0] ts_b, sv_b;
        logic [2:0]  order [4];

        // Reset state
        #1;
        check("rst_bk_rtc_wr", 64'(bk_rtc_wr), 0);
        check("rst_bk_addr",   64'(bk_addr),   0);
        check("rst_bk_data",   64'(bk_data),   0);
        check("rst_load_done", 64'(load_done), 0);
        check("rst_load_err",  64'(load_err),  0);
        check("rst_rd_data",   64'(rd_data),   0);
        check("rst_busy",      64'(busy),      0);
        check("rst_rtc_dirty", 64'(rtc_dirty), 0);
        tick(); tick();
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();

        // Out-of-order load then replay, cycle-exact
        order[0] = 3'd3; order[1] = 3'd1; order[2] = 3'd0; order[3] = 3'd2;
        for (int i = 0; i < 4; i++) ref_shadow[i] = 16'($urandom);
        pulse_load_start();
        for (int i = 0; i < 4; i++) write_word(order[i], ref_shadow[order[i][1:0]]);
        write_word(3'd4, MAGIC);
        check("emit_first_cycle_wr", 64'(bk_rtc_wr), 0);
        check("emit_busy", 64'(busy), 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("emit_wr",   64'(bk_rtc_wr), 1);
            check("emit_addr", 64'(bk_addr),   64'(k));
            check("emit_data", 64'(bk_data),   64'((k < 4) ? ref_shadow[k] : 16'h0000));
        end
        tick();
        check("emit_end_wr",   64'(bk_rtc_wr), 0);
        check("emit_done",     64'(load_done), 1);
        tick();
        check("emit_done_one", 64'(load_done), 0);
        check("emit_err",      64'(load_err),  0);
        check("emit_idle",     64'(busy),      0);

        // Missing word 3: rejected, no strobes; load_start clears the error
        pulse_load_start();
        for (int i = 0; i < 3; i++) begin
            ref_shadow[i] = 16'($urandom);
            write_word(3'(i), ref_shadow[i]);
        end
        s0 = strobe_cnt;
        write_word(3'd4, MAGIC);
        tick(); tick(); tick();
        check("partial_strobes", 64'(strobe_cnt - s0), 0);
        check("partial_err",     64'(load_err), 1);
        pulse_load_start();
        check("err_cleared",     64'(load_err), 0);

        // Bad magic
        pulse_load_start();
        load_all_words();
        s0 = strobe_cnt;
        write_word(3'd4, 16'h1234);
        tick(); tick();
        check("badmagic_strobes", 64'(strobe_cnt - s0), 0);
        check("badmagic_err",     64'(load_err), 1);

        // Known snapshot
        RTC_timestampOut = 32'h12345678;
        RTC_savedtimeOut = {16'($urandom), 32'h0ABCDEF0};
        RTC_inuse = 1'b1;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("snap_clean", 64'(rtc_dirty), 0);
        check_snapshot("snap_known", 32'h12345678, 32'h0ABCDEF0, 1'b1);

        // Random snapshots; inuse sometimes low
        for (int r = 0; r < 3; r++) begin
            ts_b = $urandom;
            sv_b = $urandom;
            RTC_timestampOut = ts_b;
            RTC_savedtimeOut = {16'($urandom), sv_b};
            RTC_inuse = 1'($urandom);
            snap_req = 1'b1;
            tick();
            snap_req = 1'b0;
            check_snapshot("snap_rand", ts_b, sv_b, RTC_inuse);
        end

        // Same-cycle read returns the old snapshot
        rd_addr = 3'd0;
        RTC_timestampOut = ts_b ^ 32'h0000FFFF;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("rd_old_snapshot", 64'(rd_data), 64'(ts_b[15:0]));
        tick();
        check("rd_new_snapshot", 64'(rd_data), 64'(ts_b[15:0] ^ 16'hFFFF));

        // Dirty tracking
        RTC_inuse = 1'b1;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        RTC_savedtimeOut[0] = ~RTC_savedtimeOut[0];
        tick();
        check("dirty_set", 64'(rtc_dirty), 1);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("dirty_cleared", 64'(rtc_dirty), 0);
        RTC_savedtimeOut[30] = ~RTC_savedtimeOut[30];
        tick();
        check("dirty_high_bits_ignored", 64'(rtc_dirty), 0);
        RTC_inuse = 1'b0;
        RTC_savedtimeOut[1] = ~RTC_savedtimeOut[1];
        tick();
        check("dirty_inuse_low", 64'(rtc_dirty), 0);
        RTC_inuse = 1'b1;
        tick();
        check("dirty_inuse_high", 64'(rtc_dirty), 1);

        // snap_req on the 2nd EMIT cycle defers capture until after the burst
        pulse_load_start();
        load_all_words();
        ts_b = $urandom;
        sv_b = $urandom;
        RTC_timestampOut = ts_b;
        RTC_savedtimeOut = {16'h0, sv_b};
        s0 = strobe_cnt;
        d0 = done_cnt;
        write_word(3'd4, MAGIC);
        tick();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("pend_busy", 64'(busy), 1);
        n = 0;
        while (busy && n < 30) begin
            if (bk_rtc_wr) check("pend_busy_during_emit", 64'(busy), 1);
            tick();
            n++;
        end
        check("pend_busy_drop_timeout", 64'(n < 30), 1);
        check("pend_strobes", 64'(strobe_cnt - s0), 5);
        check("pend_done",    64'(done_cnt - d0),   1);
        check("pend_clean",   64'(rtc_dirty), 0);
        check_snapshot("pend_snap", ts_b, sv_b, 1'b1);

        // Reset mid-EMIT
        pulse_load_start();
        load_all_words();
        write_word(3'd4, MAGIC);
        tick(); tick();
        check("mid_emit_wr", 64'(bk_rtc_wr), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_stops_wr", 64'(bk_rtc_wr), 0);
        s0 = strobe_cnt;
        tick(); tick();
        reset_n = 1'b1;
        rd_addr = 3'd0;
        for (int i = 0; i < 10; i++) tick();
        check("no_resume_strobes", 64'(strobe_cnt - s0), 0);
        check("no_resume_wr",      64'(bk_rtc_wr), 0);
        check("reset_snap_zero",   64'(rd_data), 0);
        check("reset_err_zero",    64'(load_err), 0);

        // enable low holds load_err, clears dirty and busy
        pulse_load_start();
        write_word(3'd4, MAGIC);
        check("noword_err", 64'(load_err), 1);
        enable = 1'b0;
        tick();
        check("disable_err_held", 64'(load_err), 1);
        check("disable_dirty",    64'(rtc_dirty), 0);
        check("disable_busy",     64'(busy), 0);
        enable = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
